// File: rtl/ad_regs_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad_pkg
//  Description : Shared address map constants, read codes and bus types for
//                the AD register block.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad_pkg;

  // Full fx address: [21:16] device select, [15:0] register offset
  typedef logic [21:0] fx_addr_t;

  localparam logic [15:0] c_ADDR_DEVID  = 16'h0000;
  localparam logic [15:0] c_ADDR_VER    = 16'h0001;
  localparam logic [15:0] c_ADDR_NCH    = 16'h0002;
  localparam logic [15:0] c_ADDR_STAT   = 16'h0010;  // 0x10+2c low, 0x11+2c high
  localparam logic [15:0] c_ADDR_FLAG   = 16'h0030;
  localparam logic [15:0] c_ADDR_AVE    = 16'h0040;  // 0x40+c
  localparam logic [15:0] c_ADDR_COMMIT = 16'h0050;
  localparam logic [15:0] c_ADDR_DBG    = 16'h0080;  // 0x80+i

  localparam logic [7:0]  c_UNMAPPED    = 8'h55;

endpackage : ad_pkg
`default_nettype wire

// File: rtl/ad_regs_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : ad_regs_mc_if
//  Description : fx register bus (write port, read port, registered read data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ad_regs_mc_if;
  import ad_pkg::*;

  logic       fx_wr;
  fx_addr_t   fx_waddr;
  logic [7:0] fx_data;
  logic       fx_rd;
  fx_addr_t   fx_raddr;
  logic [7:0] fx_q;

  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output fx_q
  );

endinterface : ad_regs_mc_if
`default_nettype wire

// File: rtl/ad_regs_mc_chan_stat.sv
`default_nettype none
// ============================================================================
//  Module      : ad_chan_stat
//  Description : Per-channel state: coherent high-byte shadow, new-data flag
//                and the shadow/active averaging configuration pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_chan_stat
  import ad_pkg::*;
#(
  parameter logic [7:0] AVE_RST = 8'h02
) (
  input  wire logic       clk_sys,
  input  wire logic       rst_n,
  input  wire logic [7:0] stu_hi_i,     // live status high byte
  input  wire logic       stu_vld_i,    // new-sample pulse
  input  wire logic       lo_rd_i,      // selected read of this channel's low byte
  input  wire logic       flag_clr_i,   // W1C bit for this channel
  input  wire logic       ave_wr_i,     // shadow write strobe
  input  wire logic [7:0] ave_wdata_i,
  input  wire logic       commit_i,     // copy shadow to active
  output logic [7:0]      hi_o,
  output logic            flag_o,
  output logic [7:0]      ave_sh_o,
  output logic [7:0]      ave_o
);

  logic [7:0] hi_q;
  logic       flag_q;
  logic [7:0] ave_sh_q;
  logic [7:0] ave_q;

  // Channel state; commit samples the shadow before any same-edge write lands,
  // and a new sample beats a coincident W1C so no event is lost.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= 8'h00;
      flag_q   <= 1'b0;
      ave_sh_q <= AVE_RST;
      ave_q    <= AVE_RST;
    end else begin
      if (lo_rd_i)        hi_q   <= stu_hi_i;
      if (stu_vld_i)      flag_q <= 1'b1;
      else if (flag_clr_i) flag_q <= 1'b0;
      if (ave_wr_i)       ave_sh_q <= ave_wdata_i;
      if (commit_i)       ave_q    <= ave_sh_q;
    end
  end

  assign hi_o     = hi_q;
  assign flag_o   = flag_q;
  assign ave_sh_o = ave_sh_q;
  assign ave_o    = ave_q;

endmodule : ad_chan_stat
`default_nettype wire

// File: rtl/ad_regs_mc.sv
`default_nettype none
// ============================================================================
//  Module      : ad_regs_mc
//  Description : Multi-channel AD register block on the fx bus: identity,
//                coherent 16-bit status reads, W1C new-data flags, shadowed
//                averaging config with commit, and debug scratch registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_regs_mc
  import ad_pkg::*;
#(
  parameter int         NCH     = 2,
  parameter int         NDBG    = 8,
  parameter logic [7:0] VER     = 8'h10,
  parameter logic [7:0] AVE_RST = 8'h02
) (
  input  wire logic             clk_sys,
  input  wire logic             rst_n,
  input  wire logic [5:0]       dev_id,
  ad_regs_mc_if.slave           fx,
  input  wire logic [NCH*16-1:0] stu_data,
  input  wire logic [NCH-1:0]   stu_vld,
  output logic [NCH*8-1:0]      cfg_ave,
  output logic                  cfg_upd
);

  localparam logic [3:0] c_NCH4  = 4'(NCH);
  localparam logic [4:0] c_NDBG5 = 5'(NDBG);

  logic        w_wsel, w_rsel;
  logic [15:0] w_waddr, w_raddr;
  logic        w_commit, w_flag_wr, w_ave_rgn, w_dbg_rgn, w_stat_rd;

  // Per-channel views padded to the maximum channel count so the read mux
  // can index them with the raw address bits.
  logic [7:0]  w_lo    [8];
  logic [7:0]  w_hi    [8];
  logic [7:0]  w_ave_sh[8];
  logic [7:0]  w_flags;
  logic [7:0]  w_dbg   [16];

  logic [7:0]  w_rdata;
  logic [7:0]  fx_q_q, fx_q_d;
  logic        cfg_upd_q;

  assign w_wsel  = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
  assign w_rsel  = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
  assign w_waddr = fx.fx_waddr[15:0];
  assign w_raddr = fx.fx_raddr[15:0];

  assign w_commit  = w_wsel && (w_waddr == c_ADDR_COMMIT);
  assign w_flag_wr = w_wsel && (w_waddr == c_ADDR_FLAG);
  assign w_ave_rgn = w_wsel && (w_waddr[15:3] == c_ADDR_AVE[15:3]);
  assign w_dbg_rgn = w_wsel && (w_waddr[15:4] == c_ADDR_DBG[15:4]);
  assign w_stat_rd = w_rsel && (w_raddr[15:4] == c_ADDR_STAT[15:4]) && !w_raddr[0];

  generate
    for (genvar c = 0; c < 8; c++) begin : g_ch
      if (c < NCH) begin : g_act
        ad_chan_stat #(
          .AVE_RST (AVE_RST)
        ) u_chan (
          .clk_sys     (clk_sys),
          .rst_n       (rst_n),
          .stu_hi_i    (stu_data[16*c+8 +: 8]),
          .stu_vld_i   (stu_vld[c]),
          .lo_rd_i     (w_stat_rd && (w_raddr[3:1] == 3'(c))),
          .flag_clr_i  (w_flag_wr && fx.fx_data[c]),
          .ave_wr_i    (w_ave_rgn && (w_waddr[2:0] == 3'(c))),
          .ave_wdata_i (fx.fx_data),
          .commit_i    (w_commit),
          .hi_o        (w_hi[c]),
          .flag_o      (w_flags[c]),
          .ave_sh_o    (w_ave_sh[c]),
          .ave_o       (cfg_ave[8*c +: 8])
        );
        assign w_lo[c] = stu_data[16*c +: 8];
      end else begin : g_pad
        assign w_lo[c]     = 8'h00;
        assign w_hi[c]     = 8'h00;
        assign w_ave_sh[c] = 8'h00;
        assign w_flags[c]  = 1'b0;
      end
    end

    for (genvar i = 0; i < 16; i++) begin : g_dbg
      if (i < NDBG) begin : g_reg
        logic [7:0] dbg_q;
        // Debug scratch register, reset to a recognisable per-index pattern
        always_ff @(posedge clk_sys or negedge rst_n) begin
          if (!rst_n)
            dbg_q <= 8'h80 | 8'(i);
          else if (w_dbg_rgn && (w_waddr[3:0] == 4'(i)))
            dbg_q <= fx.fx_data;
        end
        assign w_dbg[i] = dbg_q;
      end else begin : g_pad
        assign w_dbg[i] = 8'h00;
      end
    end
  endgenerate

  // Read decode from current register contents, so a same-cycle write is not visible
  always_comb begin
    w_rdata = c_UNMAPPED;
    if (w_raddr == c_ADDR_DEVID) begin
      w_rdata = {2'b00, dev_id};
    end else if (w_raddr == c_ADDR_VER) begin
      w_rdata = VER;
    end else if (w_raddr == c_ADDR_NCH) begin
      w_rdata = 8'(NCH);
    end else if (w_raddr[15:4] == c_ADDR_STAT[15:4]) begin
      if ({1'b0, w_raddr[3:1]} < c_NCH4)
        w_rdata = w_raddr[0] ? w_hi[w_raddr[3:1]] : w_lo[w_raddr[3:1]];
    end else if (w_raddr == c_ADDR_FLAG) begin
      w_rdata = w_flags;
    end else if (w_raddr[15:3] == c_ADDR_AVE[15:3]) begin
      if ({1'b0, w_raddr[2:0]} < c_NCH4)
        w_rdata = w_ave_sh[w_raddr[2:0]];
    end else if (w_raddr == c_ADDR_COMMIT) begin
      w_rdata = 8'h00;
    end else if (w_raddr[15:4] == c_ADDR_DBG[15:4]) begin
      if ({1'b0, w_raddr[3:0]} < c_NDBG5)
        w_rdata = w_dbg[w_raddr[3:0]];
    end
  end

  assign fx_q_d = w_rsel ? w_rdata : 8'h00;

  // Registered read data and commit pulse; reset drops any response in flight
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q_q    <= 8'h00;
      cfg_upd_q <= 1'b0;
    end else begin
      fx_q_q    <= fx_q_d;
      cfg_upd_q <= w_commit;
    end
  end

  assign fx.fx_q = fx_q_q;
  assign cfg_upd = cfg_upd_q;

endmodule : ad_regs_mc
`default_nettype wire

// File: tb/tb_ad_regs_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_regs_mc
//  Description : Self-checking bench for ad_regs_mc (NCH=2 main instance plus
//                an NCH=1 / NDBG=0 instance for out-of-range indices).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_regs_mc;

  localparam logic [5:0] DEV = 6'h05;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] stu_data;
  logic [1:0]  stu_vld;
  logic [15:0] cfg_ave;
  logic        cfg_upd;
  logic [15:0] stu_data1;
  logic [0:0]  stu_vld1;
  logic [7:0]  cfg_ave1;
  logic        cfg_upd1;

  int n_chk  = 0;
  int n_pass = 0;

  ad_regs_mc_if bus ();
  ad_regs_mc_if bus1 ();

  ad_regs_mc u_dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .dev_id   (DEV),
    .fx       (bus.slave),
    .stu_data (stu_data),
    .stu_vld  (stu_vld),
    .cfg_ave  (cfg_ave),
    .cfg_upd  (cfg_upd)
  );

  ad_regs_mc #(.NCH(1), .NDBG(0)) u_dut1 (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .dev_id   (DEV),
    .fx       (bus1.slave),
    .stu_data (stu_data1),
    .stu_vld  (stu_vld1),
    .cfg_ave  (cfg_ave1),
    .cfg_upd  (cfg_upd1)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        rd;
    logic [15:0] ra;
    logic        rbad;   // read with a non-matching device select
    logic        wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [7:0]  exp_q;  // fx_q one cycle later
  } vec_t;

  vec_t vt [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One bus cycle on the main instance; returns 1 time unit after the edge
  task automatic cyc(input logic rd, input logic [15:0] ra, input logic rbad,
                     input logic wr, input logic [15:0] wa, input logic [7:0] wd);
    bus.fx_rd    = rd;
    bus.fx_raddr = {(rbad ? (DEV ^ 6'h01) : DEV), ra};
    bus.fx_wr    = wr;
    bus.fx_waddr = {DEV, wa};
    bus.fx_data  = wd;
    @(posedge clk_sys);
    #1;
    bus.fx_rd = 1'b0;
    bus.fx_wr = 1'b0;
  endtask

  task automatic rd1(input logic [15:0] ra);
    bus1.fx_rd    = 1'b1;
    bus1.fx_raddr = {DEV, ra};
    @(posedge clk_sys);
    #1;
    bus1.fx_rd = 1'b0;
  endtask

  initial begin
    bus.fx_rd = 0;  bus.fx_raddr = '0;  bus.fx_wr = 0;  bus.fx_waddr = '0;  bus.fx_data = '0;
    bus1.fx_rd = 0; bus1.fx_raddr = '0; bus1.fx_wr = 0; bus1.fx_waddr = '0; bus1.fx_data = '0;
    stu_data  = 32'h1234_5A3C;
    stu_vld   = 2'b00;
    stu_data1 = 16'h0000;
    stu_vld1  = 1'b0;

    //            rd  ra        rbad wr  wa        wd     exp
    vt[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h05};
    vt[1]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h10};
    vt[2]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h02};
    vt[3]  = '{1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h80};
    vt[4]  = '{1'b1, 16'h0087, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h87};
    vt[5]  = '{1'b1, 16'h0088, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h55};
    vt[6]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h02};
    vt[7]  = '{1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h02};
    vt[8]  = '{1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h55};
    vt[9]  = '{1'b1, 16'h0050, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vt[10] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vt[11] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C};
    vt[12] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A};
    vt[13] = '{1'b1, 16'h0014, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h55};
    vt[14] = '{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vt[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0083, 8'hA5, 8'h00};
    vt[16] = '{1'b1, 16'h0083, 1'b0, 1'b1, 16'h0083, 8'h11, 8'hA5};
    vt[17] = '{1'b1, 16'h0083, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h11};
    vt[18] = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 8'hFF, 8'h10};
    vt[19] = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00};
    vt[20] = '{1'b1, 16'h0080, 1'b0, 1'b1, 16'h0099, 8'h3F, 8'h80};
    vt[21] = '{1'b1, 16'h0048, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h55};

    // Reset state
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_fx_q",    32'(bus.fx_q), 32'h00);
    check("rst_cfg_ave", 32'(cfg_ave),  32'h0202);
    check("rst_cfg_upd", 32'(cfg_upd),  32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;

    // Table-driven single-cycle accesses
    for (int k = 0; k < 22; k++) begin
      cyc(vt[k].rd, vt[k].ra, vt[k].rbad, vt[k].wr, vt[k].wa, vt[k].wd);
      check($sformatf("vec%0d", k), 32'(bus.fx_q), 32'(vt[k].exp_q));
    end

    // Coherent 16-bit status read across a live data change
    cyc(1, 16'h0012, 0, 0, 16'h0, 8'h0);
    check("stat_lo_ch1", 32'(bus.fx_q), 32'h34);
    stu_data = 32'hABCD_5A3C;
    cyc(1, 16'h0013, 0, 0, 16'h0, 8'h0);
    check("stat_hi_shadow", 32'(bus.fx_q), 32'h12);
    cyc(1, 16'h0012, 0, 0, 16'h0, 8'h0);
    check("stat_lo_new", 32'(bus.fx_q), 32'hCD);
    cyc(1, 16'h0013, 0, 0, 16'h0, 8'h0);
    check("stat_hi_new", 32'(bus.fx_q), 32'hAB);

    // Shadow write does not touch active config; commit does, with one-cycle pulse
    cyc(0, 16'h0, 0, 1, 16'h0041, 8'h07);
    check("shadow_only_ave", 32'(cfg_ave), 32'h0202);
    check("shadow_only_upd", 32'(cfg_upd), 32'h0);
    cyc(1, 16'h0041, 0, 0, 16'h0, 8'h0);
    check("shadow_rb", 32'(bus.fx_q), 32'h07);
    cyc(0, 16'h0, 0, 1, 16'h0050, 8'hC3);
    check("commit_ave", 32'(cfg_ave), 32'h0702);
    check("commit_upd", 32'(cfg_upd), 32'h1);
    cyc(0, 16'h0, 0, 0, 16'h0, 8'h0);
    check("commit_upd_drop", 32'(cfg_upd), 32'h0);
    check("commit_ave_hold", 32'(cfg_ave), 32'h0702);

    // Flags: set beats coincident W1C, W1C alone clears, one-cycle visibility latency
    stu_vld = 2'b01;
    cyc(0, 16'h0, 0, 0, 16'h0, 8'h0);
    cyc(1, 16'h0030, 0, 1, 16'h0030, 8'h01);
    check("flag_rd_pre_w1c", 32'(bus.fx_q), 32'h01);
    stu_vld = 2'b00;
    cyc(1, 16'h0030, 0, 0, 16'h0, 8'h0);
    check("flag_set_wins", 32'(bus.fx_q), 32'h01);
    cyc(0, 16'h0, 0, 1, 16'h0030, 8'h01);
    cyc(1, 16'h0030, 0, 0, 16'h0, 8'h0);
    check("flag_w1c", 32'(bus.fx_q), 32'h00);
    stu_vld = 2'b10;
    cyc(1, 16'h0030, 0, 0, 16'h0, 8'h0);
    check("flag_latency", 32'(bus.fx_q), 32'h00);
    stu_vld = 2'b00;
    cyc(1, 16'h0030, 0, 0, 16'h0, 8'h0);
    check("flag_ch1", 32'(bus.fx_q), 32'h02);

    // Single-channel, no-debug instance: out-of-range indices read as unmapped
    rd1(16'h0012);
    check("nch1_stat_ch1", 32'(bus1.fx_q), 32'h55);
    rd1(16'h0080);
    check("ndbg0_dbg0", 32'(bus1.fx_q), 32'h55);
    rd1(16'h0002);
    check("nch1_nch", 32'(bus1.fx_q), 32'h01);

    // Asynchronous reset in the middle of back-to-back reads
    cyc(1, 16'h0001, 0, 0, 16'h0, 8'h0);
    check("pre_rst_rd", 32'(bus.fx_q), 32'h10);
    bus.fx_rd    = 1'b1;
    bus.fx_raddr = {DEV, 16'h0002};
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check("async_rst_fx_q", 32'(bus.fx_q), 32'h00);
    check("async_rst_ave",  32'(cfg_ave),  32'h0202);
    @(posedge clk_sys);
    #1;
    check("rst_hold_fx_q", 32'(bus.fx_q), 32'h00);
    bus.fx_rd = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    check("post_rst_idle", 32'(bus.fx_q), 32'h00);
    cyc(1, 16'h0030, 0, 0, 16'h0, 8'h0);
    check("post_rst_flags", 32'(bus.fx_q), 32'h00);
    cyc(1, 16'h0041, 0, 0, 16'h0, 8'h0);
    check("post_rst_shadow", 32'(bus.fx_q), 32'h02);
    cyc(1, 16'h0083, 0, 0, 16'h0, 8'h0);
    check("post_rst_dbg3", 32'(bus.fx_q), 32'h83);
    cyc(1, 16'h0011, 0, 0, 16'h0, 8'h0);
    check("post_rst_hi", 32'(bus.fx_q), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ad_regs_mc
`default_nettype wire

// File: doc/ad_regs_mc.md
AD_REGS_MC -- requirements
Module: ad_regs_mc

Interface
REQ-001 SHALL have parameter NCH, default 2: number of AD channels, legal range 1..8.
REQ-002 SHALL have parameter NDBG, default 8: number of debug scratch registers, legal range 0..16.
REQ-003 SHALL have parameter VER, default 8'h10: block version byte.
REQ-004 SHALL have parameter AVE_RST, default 8'h02: reset value of every cfg_ave byte.
REQ-005 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port dev_id  in  6  device select, compared against address bits [21:16].
REQ-008 SHALL have ports fx_wr in 1, fx_waddr in 22, fx_data in 8: fx write strobe, address and data.
REQ-009 SHALL have ports fx_rd in 1, fx_raddr in 22: fx read strobe and address.
REQ-010 SHALL have port fx_q  out  8  registered read data.
REQ-011 SHALL have port stu_data  in  NCH*16  per-channel status; channel c occupies bits [16c+15:16c].
REQ-012 SHALL have port stu_vld  in  NCH  per-channel new-sample pulse.
REQ-013 SHALL have port cfg_ave  out  NCH*8  active per-channel averaging config; channel c occupies bits [8c+7:8c].
REQ-014 SHALL have port cfg_upd  out  1  one-cycle pulse, asserted the cycle active cfg_ave changes due to commit.

Function
REQ-015 SHALL treat a write as selected when fx_wr=1 and fx_waddr[21:16]=dev_id, and a read as selected when fx_rd=1 and fx_raddr[21:16]=dev_id.
REQ-016 SHALL implement this map on address bits [15:0] (c = channel, i = debug index): 0x0000 dev_id (R, zero-extended); 0x0001 VER (R); 0x0002 NCH (R); 0x0010+2c status low byte (R); 0x0011+2c status high shadow (R); 0x0030 new-data flags [NCH-1:0] (R/W1C); 0x0040+c cfg_ave shadow (RW); 0x0050 commit (W, reads 0); 0x0080+i dbg_i (RW, reset 0x80+i).
REQ-017 SHALL return fx_q exactly one cycle after a selected read; fx_q=8'h00 in any cycle following a non-selected or absent read.
REQ-018 SHALL return 8'h55 for selected reads of unmapped addresses, including channel or debug indices >= NCH or >= NDBG.
REQ-019 SHALL ignore selected writes to unmapped or read-only addresses without side effects.
REQ-020 SHALL, on a selected read of 0x0010+2c, return stu_data[c][7:0] and in the same edge latch stu_data[c][15:8] into the channel-c high shadow, making the 16-bit read coherent.
REQ-021 SHALL return the high shadow, never live data, on reads of 0x0011+2c; shadow holds until the next low-byte read of that channel.
REQ-022 SHALL set flag[c] on stu_vld[c]=1; a W1C write to 0x0030 clears bits written 1; if set and clear coincide on one bit, set SHALL win.
REQ-023 SHALL hold cfg_ave shadows separately from active cfg_ave; shadow writes SHALL NOT affect the cfg_ave outputs.
REQ-024 SHALL, on any selected write to 0x0050 (data ignored), copy all NCH shadows to active cfg_ave on that edge and assert cfg_upd for exactly that following cycle.
REQ-025 SHALL, on a commit write coinciding with a shadow write, commit the pre-write shadow value; the new value waits for the next commit.
REQ-026 SHALL process a simultaneous selected read and write in the same cycle, with the read returning pre-write register contents.
REQ-027 SHALL add a fixed latency from stu_vld to flag visibility of 1 cycle; flags are read as the registered value.

Reset
REQ-028 SHALL, while rst_n=0, force fx_q=0, cfg_upd=0, all flags=0, all high shadows=0, all cfg_ave shadows and active values=AVE_RST, and dbg_i=0x80+i.
REQ-029 SHALL abort any pending read response on reset assertion; the first fx_q after deassertion reflects only reads sampled after release.

Structure
REQ-030 SHALL place address constants (0x0000, 0x0001, 0x0002, 0x0010, 0x0030, 0x0040, 0x0050, 0x0080) and the 8'h55 unmapped code in shared package ad_pkg.
REQ-031 SHALL use one sub-module, ad_chan_stat, instantiated NCH times, holding one channel's high shadow, flag and cfg_ave shadow/active pair.

Verification
REQ-032 Reset then read 0x0001, 0x0002, 0x0080, 0x0040 -> fx_q 0x10, 0x02, 0x80, 0x02, each one cycle after fx_rd.
REQ-033 stu_data ch1=0x1234; read 0x0012; change to 0xABCD; read 0x0013 -> 0x34 then 0x12, not 0xAB.
REQ-034 Write 0x0041=0x07 -> cfg_ave[15:8] stays 0x02; write 0x0050 -> cfg_ave[15:8]=0x07 and cfg_upd high exactly one cycle.
REQ-035 Pulse stu_vld[0], then write 0x0030=0x01 in the same cycle as another stu_vld[0] pulse -> flag[0] remains 1; later W1C alone -> reads 0x00.
REQ-036 Read 0x0012 with NCH=1, and read with fx_raddr[21:16]!=dev_id -> 0x55 and 0x00 respectively.
REQ-037 Assert rst_n low mid-read and after a committed cfg_ave=0x07 -> fx_q=0, cfg_ave=0x02, flags cleared.
